toggle_line_decoder: RTL and testbench
======================================

Name: toggle_line_decoder

Overview:
- Receive-side companion of the dual-lane toggle encoder, recovering the original serial bit stream from its three line outputs.
- The encoder drives three lines:
  - Lane A toggles on each 1 bit.
  - Lane B toggles on each 0 bit.
  - Lane N is the registered complement of lane A.
- The decoder recovers bits from lane A and cross-checks lane B and lane N.
- It hunts for a sync word, then assembles fixed-length frames of LSB-first bytes for the downstream byte consumer.

Parameters:
- SYNC_WORD, 8'hA5: 8-bit sync pattern, matched LSB-first (first received bit = bit 0).
- FRAME_BYTES, 4: number of data bytes per frame after sync, range 1..255.
- CHECK_LANES, 1: 1 = enable lane B and lane N checks; 0 = decode from lane A only and never raise err.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- sample_en, input, 1: line sample strobe; the lines are sampled only on edges where this is 1.
- line_a, input, 1: lane A, toggles on data 1.
- line_b, input, 1: lane B, toggles on data 0.
- line_n, input, 1: lane N, complement of lane A.
- data_out, output, 8: assembled byte; held between updates.
- data_valid, output, 1: 1-cycle pulse; data_out is new.
- frame_start, output, 1: 1-cycle pulse; sync word matched.
- frame_end, output, 1: 1-cycle pulse; last byte of frame delivered.
- in_frame, output, 1: level; high while in DATA state.
- err, output, 1: 1-cycle pulse; line check failed.
- err_code, output, 2: cause of last error, held until next error; 01 = lane N, 10 = lane B, 11 = both.

Behaviour:
- All outputs are registered.
- Reset values: data_out = 0, data_valid = 0, frame_start = 0, frame_end = 0, in_frame = 0, err = 0, err_code = 0; state = HUNT; primed = 0; prev_a = 0; prev_b = 0; history = 0; hist_cnt = 0; bit_cnt = 0; byte_cnt = 0.
- sample_en = 0: all internal state holds; pulse outputs are 0 that cycle.
- Priming: the first enabled sample after reset only loads prev_a = line_a and prev_b = line_b, then sets primed = 1. No decode and no checks on that sample.
- Decode, per enabled primed sample:
  - d = line_a ^ prev_a.
  - Lane B check: (line_b ^ prev_b) must equal ~d.
  - Lane N check: line_n must equal ~line_a.
  - prev_a and prev_b are updated every enabled sample, including failing ones.
- Error, any state, when CHECK_LANES = 1:
  - err pulses and err_code is set per the cause.
  - The bit is discarded; history and hist_cnt are cleared.
  - Any partial byte is discarded; bit_cnt = 0, byte_cnt = 0.
  - state goes to HUNT and in_frame = 0; no frame_end is issued.
- HUNT state:
  - history shifts right with d entering bit 7.
  - hist_cnt counts up, saturating at 8.
  - When hist_cnt reaches 8 and the updated history equals SYNC_WORD: frame_start pulses, state goes to DATA, in_frame = 1, bit_cnt = 0, byte_cnt = 0.
  - Overlapping sync search: no clear on mismatch; history keeps sliding.
- DATA state:
  - d shifts into the byte register LSB-first and bit_cnt increments.
  - On the 8th bit: data_out = the assembled byte, data_valid pulses, bit_cnt = 0, byte_cnt increments.
  - When byte_cnt reaches FRAME_BYTES:
    - frame_end pulses in the same cycle as that data_valid.
    - state goes to HUNT, in_frame = 0.
    - history and hist_cnt are cleared, so data bits never match as sync.
- Latency: an event caused by the sample taken at edge k is visible on the outputs from edge k until edge k+1, i.e. one cycle.
- Reset mid-frame: everything returns to reset values, including primed = 0; no frame_end is issued.

Test Plan:
- Sync detection: after reset, prime with A=0, B=0, N=1. Feed 0xA5 LSB-first, i.e. bits 1,0,1,0,0,1,0,1, with consistent B and N.
  - Required: frame_start pulses one cycle after the 8th sample; in_frame = 1.
- Full frame: after sync, send bytes 0x3C, 0xFF, 0x00, 0x81.
  - Required: four data_valid pulses with data_out = 0x3C, 0xFF, 0x00, 0x81.
  - Required: frame_end coincides with the 0x81 pulse; in_frame drops; the next sync is detected again.
- Stall tolerance: same frame with sample_en toggled randomly 50%.
  - Required: identical byte sequence.
  - Required: no pulses during sample_en = 0 cycles.
- Lane B fault: force lane B not to toggle on the 3rd data bit of byte 2.
  - Required: err pulses with err_code = 10, in_frame = 0, no frame_end, no further data_valid until a new sync.
- Lane N fault in HUNT: drive line_n = line_a for one sample.
  - Required: err pulses with err_code = 01, history is cleared, and sync needs 8 fresh bits.
  - Same fault with CHECK_LANES = 0: no err, and decoding proceeds.
- Reset mid-frame: assert rst after byte 1 of a frame.
  - Required: all outputs are 0 next cycle.
  - Required: the first sample after release is priming only; a subsequent full sync and frame decodes correctly.

Source files
------------

// File: rtl/toggle_line_decoder.sv
// toggle_line_decoder: recovers bits from dual-lane toggle lines, hunts sync, frames LSB-first bytes
module toggle_line_decoder #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter int FRAME_BYTES = 4,
  parameter bit CHECK_LANES = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic sample_en,
  input logic line_a,
  input logic line_b,
  input logic line_n,
  output logic [7:0] data_out,
  output logic data_valid,
  output logic frame_start,
  output logic frame_end,
  output logic in_frame,
  output logic err,
  output logic [1:0] err_code
);
  typedef enum logic {HUNT, DATA} state_t;
  state_t state, state_n;
  logic primed, primed_n, prev_a, prev_a_n, prev_b, prev_b_n;
  logic [7:0] history, history_n, shreg, shreg_n, byte_cnt, byte_cnt_n, data_out_n;
  logic [3:0] hist_cnt, hist_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic data_valid_n, frame_start_n, frame_end_n, in_frame_n, err_n;
  logic [1:0] err_code_n;
  logic d, b_bad, n_bad;
  // decoded bit and lane consistency checks for the current sample
  always_comb begin
    d = line_a ^ prev_a;
    b_bad = CHECK_LANES && ((line_b ^ prev_b) == d);
    n_bad = CHECK_LANES && (line_n == line_a);
  end
  // next-state and registered-output computation; pulses default low
  always_comb begin
    state_n = state;
    primed_n = primed;
    prev_a_n = prev_a;
    prev_b_n = prev_b;
    history_n = history;
    hist_cnt_n = hist_cnt;
    shreg_n = shreg;
    bit_cnt_n = bit_cnt;
    byte_cnt_n = byte_cnt;
    data_out_n = data_out;
    data_valid_n = 1'b0;
    frame_start_n = 1'b0;
    frame_end_n = 1'b0;
    in_frame_n = in_frame;
    err_n = 1'b0;
    err_code_n = err_code;
    if (sample_en && !primed) begin
      primed_n = 1'b1;
      prev_a_n = line_a;
      prev_b_n = line_b;
    end else if (sample_en) begin
      prev_a_n = line_a;
      prev_b_n = line_b;
      if (b_bad || n_bad) begin
        err_n = 1'b1;
        err_code_n = {b_bad, n_bad};
        history_n = 8'd0;
        hist_cnt_n = 4'd0;
        bit_cnt_n = 3'd0;
        byte_cnt_n = 8'd0;
        state_n = HUNT;
        in_frame_n = 1'b0;
      end else if (state == HUNT) begin
        history_n = {d, history[7:1]};
        hist_cnt_n = (hist_cnt == 4'd8) ? 4'd8 : hist_cnt + 4'd1;
        if (hist_cnt_n == 4'd8 && history_n == SYNC_WORD) begin
          frame_start_n = 1'b1;
          state_n = DATA;
          in_frame_n = 1'b1;
          bit_cnt_n = 3'd0;
          byte_cnt_n = 8'd0;
        end
      end else begin
        shreg_n = {d, shreg[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          data_out_n = shreg_n;
          data_valid_n = 1'b1;
          byte_cnt_n = byte_cnt + 8'd1;
          if (byte_cnt_n == 8'(FRAME_BYTES)) begin
            frame_end_n = 1'b1;
            state_n = HUNT;
            in_frame_n = 1'b0;
            history_n = 8'd0;
            hist_cnt_n = 4'd0;
          end
        end
      end
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      primed <= 1'b0;
      prev_a <= 1'b0;
      prev_b <= 1'b0;
      history <= 8'd0;
      hist_cnt <= 4'd0;
      shreg <= 8'd0;
      bit_cnt <= 3'd0;
      byte_cnt <= 8'd0;
      data_out <= 8'd0;
      data_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      in_frame <= 1'b0;
      err <= 1'b0;
      err_code <= 2'd0;
    end else begin
      state <= state_n;
      primed <= primed_n;
      prev_a <= prev_a_n;
      prev_b <= prev_b_n;
      history <= history_n;
      hist_cnt <= hist_cnt_n;
      shreg <= shreg_n;
      bit_cnt <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      data_out <= data_out_n;
      data_valid <= data_valid_n;
      frame_start <= frame_start_n;
      frame_end <= frame_end_n;
      in_frame <= in_frame_n;
      err <= err_n;
      err_code <= err_code_n;
    end
  end
endmodule

// File: tb/tb_toggle_line_decoder.sv
// tb_toggle_line_decoder: directed checks of sync, framing, stalls, lane faults and reset
module tb_toggle_line_decoder;
  logic clk = 1'b0, rst = 1'b1, sample_en = 1'b0, line_a = 1'b0, line_b = 1'b0, line_n = 1'b1;
  logic [7:0] data_out, data_out0;
  logic data_valid, frame_start, frame_end, in_frame, err;
  logic data_valid0, frame_start0, frame_end0, in_frame0, err0;
  logic [1:0] err_code, err_code0;
  int checks = 0, errors = 0;
  int n_dv, n_fs, n_fe, n_err, n_fs0, n_err0;
  logic stall = 1'b0, stall_bad;
  logic ea = 1'b0, eb = 1'b0;
  logic [7:0] got[$];
  logic [7:0] frame_bytes [4] = '{8'h3C, 8'hFF, 8'h00, 8'h81};

  toggle_line_decoder dut (.clk(clk), .rst(rst), .sample_en(sample_en), .line_a(line_a), .line_b(line_b),
    .line_n(line_n), .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
    .frame_end(frame_end), .in_frame(in_frame), .err(err), .err_code(err_code));
  toggle_line_decoder #(.CHECK_LANES(1'b0)) dut0 (.clk(clk), .rst(rst), .sample_en(sample_en), .line_a(line_a),
    .line_b(line_b), .line_n(line_n), .data_out(data_out0), .data_valid(data_valid0), .frame_start(frame_start0),
    .frame_end(frame_end0), .in_frame(in_frame0), .err(err0), .err_code(err_code0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_dv = 0; n_fs = 0; n_fe = 0; n_err = 0; n_fs0 = 0; n_err0 = 0;
    stall_bad = 1'b0;
    got.delete();
  endtask

  task automatic idle();
    sample_en = 1'b0;
    @(posedge clk); #1;
    if (data_valid || frame_start || frame_end || err) stall_bad = 1'b1;
  endtask

  task automatic send_bit(input logic d, input logic fault_b, input logic fault_n);
    if (stall) repeat ($urandom_range(2, 0)) idle();
    if (d) ea = ~ea;
    else if (!fault_b) eb = ~eb;
    line_a = ea;
    line_b = eb;
    line_n = fault_n ? ea : ~ea;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    if (data_valid) begin n_dv++; got.push_back(data_out); end
    if (frame_start) n_fs++;
    if (frame_end) n_fe++;
    if (err) n_err++;
    if (frame_start0) n_fs0++;
    if (err0) n_err0++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0, 1'b0);
  endtask

  task automatic prime();
    line_a = ea;
    line_b = eb;
    line_n = ~ea;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
  endtask

  task automatic sync_check(input string tag);
    clr();
    send_byte(8'hA5);
    chk({tag, "_fs_cnt"}, n_fs, 1);
    chk({tag, "_fs_last"}, frame_start, 1);
    chk({tag, "_in_frame"}, in_frame, 1);
  endtask

  task automatic frame_check(input string tag);
    clr();
    for (int i = 0; i < 4; i++) send_byte(frame_bytes[i]);
    chk({tag, "_dv_cnt"}, n_dv, 4);
    for (int i = 0; i < 4; i++) chk({tag, "_byte"}, (got.size() > i) ? got[i] : 8'hxx, frame_bytes[i]);
    chk({tag, "_fe_cnt"}, n_fe, 1);
    chk({tag, "_fe_with_dv"}, {frame_end, data_valid, data_out}, {1'b1, 1'b1, 8'h81});
    chk({tag, "_in_frame_drop"}, in_frame, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {data_out, data_valid, frame_start, frame_end, in_frame, err, err_code}, 0);
    chk("rst_outs_nc", {data_out0, data_valid0, frame_start0, frame_end0, in_frame0, err0, err_code0}, 0);
    rst = 1'b0;
    prime();
    chk("prime_quiet", {data_valid, frame_start, frame_end, in_frame, err}, 0);
    sync_check("sync1");
    frame_check("frame1");
    sync_check("sync2");
    stall = 1'b1;
    frame_check("stall");
    chk("stall_no_pulse", stall_bad, 0);
    stall = 1'b0;
    sync_check("sync3");
    clr();
    send_byte(8'h3C);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    chk("bflt_err", {err, err_code}, {1'b1, 2'b10});
    chk("bflt_in_frame", in_frame, 0);
    clr();
    for (int i = 3; i < 8; i++) send_bit(1'b0, 1'b0, 1'b0);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("bflt_no_dv", n_dv, 0);
    chk("bflt_no_fe", n_fe, 0);
    chk("bflt_code_held", {err, err_code}, {1'b0, 2'b10});
    clr();
    for (int i = 0; i < 4; i++) send_bit(frame_bytes[0][i] ^ 1'b0, 1'b0, 1'b0);
    clr();
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b1);
    chk("nflt_err", {err, err_code}, {1'b1, 2'b01});
    chk("nflt_nc_no_err", n_err0, 0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    chk("nflt_no_early_sync", n_fs, 0);
    chk("nflt_nc_synced", {n_fs0, in_frame0}, {32'd1, 1'b1});
    sync_check("nflt_resync");
    frame_check("frame2");
    sync_check("sync4");
    clr();
    send_byte(8'h3C);
    chk("mid_byte1", {n_dv, data_out}, {32'd1, 8'h3C});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_outs", {data_out, data_valid, frame_start, frame_end, in_frame, err, err_code}, 0);
    rst = 1'b0;
    ea = ~ea;
    prime();
    chk("rst_prime_quiet", {data_out, data_valid, frame_start, frame_end, in_frame, err}, 0);
    sync_check("sync5");
    frame_check("frame3");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
